// File: rtl/burst_writer_pkg.sv
`timescale 1ns/1ps
// burst_writer_pkg: shared types and constants for the burst_writer block.
// Contents: FSM state enum, AXI burst/response encodings, byte-stride helper.
// No logic; imported by burst_writer.
package burst_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Bytes covered by one full burst; the address step between bursts.
    function automatic int unsigned burst_stride_bytes(input int unsigned burst_length,
                                                       input int unsigned data_width);
        return burst_length * (data_width / 8);
    endfunction

endpackage

// File: rtl/burst_writer.sv
`timescale 1ns/1ps
// burst_writer: drains a source FIFO into num_bursts fixed-length AXI4 INCR write bursts.
// Latency: awvalid one cycle after an accepted start; W beats pop the FIFO with zero latency.
// Backpressure: holds AW/W payload until awready/wready; one burst outstanding until its B.
//
// Ports:
//   clk, rst (async, active-high)
//   start/base_addr/num_bursts -> job request; busy/done (1-cycle pulse)/error (sticky) -> status
//   fifo_empty/fifo_dout/fifo_ren -> read side of the external source FIFO (show-ahead)
//   aw*/w*/b* -> AXI4 write address, data and response channels
//
// Build option: define BURST_WRITER_ABORT_ON_ERR_EN to end the job at the first
// SLVERR/DECERR response instead of completing every requested burst.
module burst_writer
    import burst_writer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LENGTH = 128,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [15:0]               num_bursts,
    output logic                      busy,
    output logic                      done,
    output logic                      error,

    input  logic                      fifo_empty,
    input  logic [DATA_WIDTH-1:0]     fifo_dout,
    output logic                      fifo_ren,

    output logic                      awvalid,
    input  logic                      awready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,

    output logic                      wvalid,
    input  logic                      wready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,

    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp
);

    localparam int                    STRB_WIDTH  = DATA_WIDTH / 8;
    localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LENGTH - 1);
    localparam logic [2:0]            AW_SIZE     = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ADDR_STRIDE =
        ADDR_WIDTH'(burst_stride_bytes(BURST_LENGTH, DATA_WIDTH));

    state_t      state;
    logic [7:0]  beat_cnt;
    logic [15:0] bursts_left;
    logic        w_hs;
    logic        resp_err;
    logic        job_end;

    // The FIFO is show-ahead, so the head word is the beat on offer. wvalid can
    // only fall through a pop, which is exactly a W handshake, so it never
    // retracts an un-accepted beat.
    assign wvalid   = (state == ST_DATA) && !fifo_empty;
    assign w_hs     = wvalid && wready;
    assign fifo_ren = w_hs;
    assign wdata    = fifo_dout;
    assign wstrb    = '1;
    assign wlast    = (state == ST_DATA) && (beat_cnt == LAST_BEAT);

    assign awsize   = AW_SIZE;
    assign awburst  = AXI_BURST_INCR;

    assign resp_err = (bresp == RESP_SLVERR) || (bresp == RESP_DECERR);

`ifdef BURST_WRITER_ABORT_ON_ERR_EN
    assign job_end  = (bursts_left == 16'd1) || resp_err;
`else
    assign job_end  = (bursts_left == 16'd1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            awvalid     <= 1'b0;
            awaddr      <= '0;
            awlen       <= '0;
            bready      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            beat_cnt    <= '0;
            bursts_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (num_bursts == 16'd0) begin
                            // Empty job: acknowledge without touching the bus.
                            done <= 1'b1;
                        end else begin
                            awaddr      <= base_addr;
                            awlen       <= LAST_BEAT;
                            bursts_left <= num_bursts;
                            awvalid     <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ST_ADDR;
                        end
                    end
                end

                ST_ADDR: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_hs) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            bready   <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end

                ST_RESP: begin
                    if (bvalid) begin
                        bready      <= 1'b0;
                        bursts_left <= bursts_left - 16'd1;
                        if (resp_err) begin
                            error <= 1'b1;
                        end
                        if (job_end) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            // Next AW is raised only here, after B, so at most
                            // one burst is ever outstanding.
                            awaddr  <= awaddr + ADDR_STRIDE;
                            awvalid <= 1'b1;
                            state   <= ST_ADDR;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_writer.sv
`timescale 1ns/1ps
// tb_burst_writer: randomized scoreboard bench for burst_writer (BURST_LENGTH=4).
// Stimulus plans expected AW addresses, W words, responses and done status in
// tables; a negedge monitor pops and compares whenever the DUT shows traffic.
module tb_burst_writer;
    import burst_writer_pkg::*;

    localparam int DW     = 32;
    localparam int BL     = 4;
    localparam int AWD    = 32;
    localparam int STRIDE = BL * DW / 8;
`ifdef BURST_WRITER_ABORT_ON_ERR_EN
    localparam int ERR_BURSTS = 1;
`else
    localparam int ERR_BURSTS = 3;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start;
    logic [AWD-1:0]  base_addr;
    logic [15:0]     num_bursts;
    logic            busy, done, error;
    logic            fifo_empty = 1'b1;
    logic [DW-1:0]   fifo_dout  = '0;
    logic            fifo_ren;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [AWD-1:0]  awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            wvalid;
    logic            wready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid = 1'b0;
    logic            bready;
    logic [1:0]      bresp = 2'b00;

    burst_writer #(.DATA_WIDTH(DW), .BURST_LENGTH(BL), .ADDR_WIDTH(AWD)) dut (
        .clk(clk), .rst(rst),
        .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
        .busy(busy), .done(done), .error(error),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_ren(fifo_ren),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    logic [47:0] out_vec;
    assign out_vec = {awvalid, wvalid, bready, fifo_ren, busy, done, error, wlast, awaddr, awlen};

    int n_cmp = 0;
    int n_bad = 0;

    // Plan tables (written by stimulus, read by monitor/slave).
    logic [31:0] aw_mem   [0:255];
    logic [1:0]  resp_mem [0:255];
    logic        done_mem [0:63];
    int          aw_planned   = 0;
    int          done_planned = 0;
    int          feed_target  = 0;
    int          feed_prob    = 100;
    int          aw_delay     = 0;
    int          w_mode       = 0;
    int          b_prob       = 100;

    // Source FIFO model.
    logic [31:0] fifo_q [$];
    logic [31:0] exp_mem [0:4095];
    int          fed_total = 0;

    // Monitor-owned observations.
    logic        pop_req = 1'b0;
    logic        b_hs = 1'b0;
    int          aw_wait = 0;
    int          w_beats = 0;
    int          wl_total = 0;
    int          aw_total = 0;
    int          done_total = 0;
    int          outstanding = 0;
    int          beat_pos = 0;
    logic        aw_hold = 1'b0, w_hold = 1'b0, prev_done = 1'b0;
    logic [31:0] aw_hold_addr = '0, w_hold_dat = '0;

    int          b_issued = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO: pops what the DUT took at the last edge, then refills toward feed_target.
    always @(posedge clk) begin
        logic [31:0] w;
        #1;
        if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (fed_total < feed_target && $urandom_range(0, 99) < feed_prob) begin
            w = $urandom;
            exp_mem[fed_total] = w;
            fifo_q.push_back(w);
            fed_total++;
            if (feed_prob < 100) break;
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
    end

    // AXI slave: AW delay, W ready pattern, B issued per completed burst from the plan.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            bresp   = RESP_OKAY;
        end else begin
            awready = (aw_wait >= aw_delay);
            case (w_mode)
                0:       wready = 1'b1;
                1:       wready = !wready;
                default: wready = 1'($urandom_range(0, 1));
            endcase
            if (bvalid && b_hs) bvalid = 1'b0;
            if (!bvalid && b_issued < wl_total && $urandom_range(0, 99) < b_prob) begin
                bvalid = 1'b1;
                bresp  = resp_mem[b_issued];
                b_issued++;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            pop_req = 1'b0; b_hs = 1'b0; aw_wait = 0; outstanding = 0; beat_pos = 0;
            aw_hold = 1'b0; w_hold = 1'b0; prev_done = 1'b0;
        end else begin
            pop_req = fifo_ren;
            b_hs    = bvalid && bready;

            if (prev_done) check("done_width", done, 0);
            if (done) begin
                check("done_planned", done_total < done_planned, 1);
                check("done_error", error, done_mem[done_total]);
                check("done_busy", busy, 0);
                done_total++;
            end
            prev_done = done;

            if (aw_hold) begin
                check("aw_hold_valid", awvalid, 1);
                check("aw_hold_addr", awaddr, aw_hold_addr);
            end
            if (awvalid && awready) begin
                check("aw_planned", aw_total < aw_planned, 1);
                check("aw_addr", awaddr, aw_mem[aw_total]);
                check("aw_len", awlen, BL - 1);
                check("aw_size", awsize, 2);
                check("aw_burst", awburst, 1);
                check("aw_one_outstanding", outstanding, 0);
                aw_total++;
                outstanding++;
                aw_wait = 0;
            end else if (awvalid) begin
                aw_wait++;
            end
            aw_hold      = awvalid && !awready;
            aw_hold_addr = awaddr;

            if (w_hold) begin
                check("w_hold_valid", wvalid, 1);
                check("w_hold_data", wdata, w_hold_dat);
            end
            if (fifo_empty) check("w_empty_novalid", wvalid, 0);
            if (wvalid || fifo_ren) check("fifo_ren", fifo_ren, wvalid && wready);
            if (wvalid && wready) begin
                check("w_avail", w_beats < fed_total, 1);
                check("w_data", wdata, exp_mem[w_beats]);
                check("w_strb", wstrb, 4'hF);
                check("w_last", wlast, beat_pos == BL - 1);
                check("w_after_aw", outstanding, 1);
                w_beats++;
                if (beat_pos == BL - 1) begin
                    beat_pos = 0;
                    wl_total++;
                end else begin
                    beat_pos++;
                end
            end
            w_hold     = wvalid && !wready;
            w_hold_dat = wdata;

            if (bvalid && bready) begin
                check("b_outstanding", outstanding, 1);
                outstanding--;
            end
        end
    end

    // Plan one job, start it, wait for done, then check beat/burst totals.
    // ext_words: words of this job already supplied outside this task.
    task automatic run_job(input logic [31:0] base, input int n, input logic [7:0] emask,
                           input bit pre, input bit poke, input int ext_words);
        int exec, t, w0, d0, l0, feed;
        logic err;
        exec = n;
        err  = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (emask[i]) begin
                err = 1'b1;
`ifdef BURST_WRITER_ABORT_ON_ERR_EN
                exec = i + 1;
`endif
            end
        end
        for (int i = 0; i < exec; i++) begin
            aw_mem[aw_total + i]   = base + 32'(i * STRIDE);
            resp_mem[wl_total + i] = emask[i] ? (($urandom_range(0, 1) == 1) ? RESP_SLVERR : RESP_DECERR)
                                              : RESP_OKAY;
        end
        aw_planned             = aw_total + exec;
        done_mem[done_total]   = err;
        done_planned           = done_total + 1;
        feed = exec * BL - ext_words;
        w0 = w_beats; d0 = done_total; l0 = wl_total;
        if (pre) begin
            feed_target += feed;
            repeat (3) tick();
        end
        start = 1'b1; base_addr = base; num_bursts = 16'(n);
        tick();
        start = 1'b0;
        if (!pre) feed_target += feed;
        if (poke) begin
            tick();
            start = 1'b1; base_addr = ~base; num_bursts = 16'd0;
            tick();
            start = 1'b0;
        end
        t = 0;
        while (done_total == d0 && t < 4000) begin
            tick();
            t++;
        end
        check("job_done", done_total - d0, 1);
        check("job_beats", w_beats - w0, exec * BL);
        check("job_bursts", wl_total - l0, exec);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, t, wl0, d0;
        start = 1'b0; base_addr = '0; num_bursts = '0;

        #3;
        check("reset_outputs", out_vec, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_awvalid", awvalid, 0);
        tick();

        // Two bursts from 0x1000, FIFO prefilled, always-ready slave.
        run_job(32'h0000_1000, 2, 8'h00, 1, 0, 0);

        // FIFO runs dry after two beats and refills five cycles later.
        w0 = w_beats;
        fork
            run_job(32'h0000_3000, 1, 8'h00, 0, 0, 4);
            begin
                feed_target += 2;
                t = 0;
                while (w_beats < w0 + 2 && t < 200) begin
                    tick();
                    t++;
                end
                check("gap_two_beats", w_beats - w0, 2);
                repeat (5) begin
                    @(negedge clk);
                    check("gap_wvalid_low", wvalid, 0);
                    check("gap_busy", busy, 1);
                end
                feed_target += 2;
            end
        join

        // Slow AW acceptance and alternating wready.
        aw_delay = 3; w_mode = 1;
        run_job(32'h0000_4000, 2, 8'h00, 1, 0, 0);
        aw_delay = 0; w_mode = 0;

        // Error response on the first of three bursts.
        wl0 = wl_total;
        run_job(32'h0000_5000, 3, 8'h01, 1, 0, 0);
        check("err_burst_count", wl_total - wl0, ERR_BURSTS);
        repeat (3) tick();
        @(negedge clk);
        check("err_sticky", error, 1);
        tick();

        // Zero-burst job: done next cycle, no AW, and error cleared by the start.
        done_mem[done_total] = 1'b0;
        done_planned = done_total + 1;
        aw_planned   = aw_total;
        d0 = done_total;
        start = 1'b1; base_addr = 32'h0000_7000; num_bursts = 16'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_awvalid", awvalid, 0);
        check("zero_error_cleared", error, 0);
        repeat (3) tick();
        check("zero_done_count", done_total - d0, 1);

        // Start pulsed again while busy must be ignored.
        run_job(32'h0000_6000, 2, 8'h00, 1, 1, 0);

        // Reset in the middle of a data phase, then a fresh job from a new base.
        feed_target += 3;
        repeat (2) tick();
        w0 = w_beats;
        aw_mem[aw_total] = 32'h0000_2000;
        aw_planned   = aw_total + 1;
        done_planned = done_total;
        start = 1'b1; base_addr = 32'h0000_2000; num_bursts = 16'd2;
        tick();
        start = 1'b0;
        t = 0;
        while (w_beats < w0 + 2 && t < 100) begin
            tick();
            t++;
        end
        check("rst_reached_data", w_beats - w0, 2);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_outputs", out_vec, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        run_job(32'h0000_8000, 1, 8'h00, 0, 0, 1);

        // Address wrap at the top of the address space.
        run_job(32'hFFFF_FFF0, 2, 8'h00, 1, 0, 0);

        // Randomized jobs.
        for (int j = 0; j < 10; j++) begin
            aw_delay  = $urandom_range(0, 3);
            w_mode    = $urandom_range(0, 2);
            b_prob    = $urandom_range(30, 100);
            feed_prob = $urandom_range(20, 99);
            run_job(32'($urandom) & 32'hFFFF_FFFC, $urandom_range(1, 4),
                    ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 15)) : 8'h00,
                    0, ($urandom_range(0, 3) == 0), 0);
        end

        repeat (5) tick();
        @(negedge clk);
        check("fifo_drained", fifo_empty, 1);
        check("end_idle", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_writer.md
BURST_WRITER -- requirements
Module: burst_writer

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 32, the FIFO word and AXI W data width in bits.
REQ-002 SHALL expose parameter BURST_LENGTH, default 128, the beats per AXI burst; legal range 1..256.
REQ-003 SHALL expose parameter ADDR_WIDTH, default 32, the AXI address width.
REQ-004 SHALL have port clk, input, 1 bit: the clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports start (in, 1), base_addr (in, ADDR_WIDTH) and num_bursts (in, 16): job request, start byte address and burst count.
REQ-007 SHALL have ports busy (out, 1), done (out, 1, single-cycle pulse) and error (out, 1, sticky): job status.
REQ-008 SHALL have ports fifo_empty (in, 1), fifo_dout (in, DATA_WIDTH) and fifo_ren (out, 1): the read side of the source FIFO; fifo_dout is valid combinationally whenever fifo_empty is low.
REQ-009 SHALL have AXI4 AW ports awvalid (out), awready (in), awaddr (out, ADDR_WIDTH), awlen (out, 8), awsize (out, 3) and awburst (out, 2).
REQ-010 SHALL have AXI4 W ports wvalid (out), wready (in), wdata (out, DATA_WIDTH), wstrb (out, DATA_WIDTH/8) and wlast (out).
REQ-011 SHALL have AXI4 B ports bvalid (in), bready (out) and bresp (in, 2).

Function
REQ-012 SHALL implement the FSM states IDLE, ADDR, DATA and RESP.
REQ-013 IDLE -> ADDR SHALL occur on start=1; base_addr and num_bursts SHALL be captured on that edge, and awvalid SHALL assert the next cycle.
REQ-014 start while busy SHALL be ignored; start with num_bursts=0 SHALL produce a done pulse the next cycle with no AXI traffic.
REQ-015 In ADDR: awvalid=1; awaddr, awlen=BURST_LENGTH-1, awsize=log2(DATA_WIDTH/8) and awburst=INCR SHALL be held stable until awready; on handshake the FSM SHALL go to DATA.
REQ-016 In DATA: wvalid=!fifo_empty; wdata=fifo_dout; wstrb all ones; fifo_ren=wvalid&&wready (zero-latency pop).
REQ-017 Because the FIFO only drains through fifo_ren, wvalid once asserted SHALL stay high until its handshake.
REQ-018 A beat counter SHALL count W handshakes; wlast SHALL be 1 exactly on beat BURST_LENGTH-1; the FSM SHALL go to RESP after that handshake.
REQ-019 In RESP: bready=1; on bvalid, if bresp is SLVERR or DECERR, error SHALL set.
REQ-020 In RESP, on bvalid with bursts remaining, awaddr SHALL advance by BURST_LENGTH*DATA_WIDTH/8 (modulo 2^ADDR_WIDTH) and the FSM SHALL go to ADDR.
REQ-021 In RESP, on bvalid with no bursts remaining, the FSM SHALL go to IDLE, busy SHALL drop and done SHALL pulse, all on the same edge.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 The writer SHALL never issue a new AW before the previous B handshake (one outstanding burst).
REQ-024 error SHALL clear only on an accepted start or on rst.

Reset
REQ-025 On rst the FSM SHALL return to IDLE immediately, including mid-burst.
REQ-026 On rst all valid/ready/ren outputs, busy, done, error, wlast, awaddr, awlen and the counters SHALL go to 0.
REQ-027 The FIFO is not touched by reset; a partial burst is abandoned.

Configuration
REQ-028 The macro BURST_WRITER_ABORT_ON_ERR_EN, when defined, SHALL make an error response end the job: go to IDLE and pulse done, with error=1.
REQ-029 When BURST_WRITER_ABORT_ON_ERR_EN is undefined, an error response SHALL only set error, and all num_bursts bursts SHALL complete.

Structure
REQ-030 Package burst_writer_pkg SHALL hold the state enum, the AXI_BURST_INCR, RESP_OKAY, RESP_SLVERR and RESP_DECERR constants, and the byte-stride function.
REQ-031 The block SHALL be a single module with no sub-module; the FIFO is external (ring buffer instance).

Verification
REQ-032 A bench SHALL cover: BURST_LENGTH=4, base 0x1000, num_bursts=2, FIFO prefilled 8 words, always-ready slave -> AW at 0x1000 then 0x1010, awlen=3, wlast on beats 3 and 7, one done pulse.
REQ-033 A bench SHALL cover: FIFO empty after 2 beats, refilled 5 cycles later -> wvalid low during the gap, no beat lost or duplicated, data order preserved.
REQ-034 A bench SHALL cover: awready delayed 3 cycles and wready toggling 1/0 -> awaddr and wdata stable while unaccepted, exactly 4 pops per burst.
REQ-035 A bench SHALL cover: bresp=SLVERR on burst 1 of 3 -> error=1; with the macro, done after burst 1; without it, done after burst 3.
REQ-036 A bench SHALL cover: rst asserted mid-DATA -> all outputs 0 the same cycle; a new start then runs from the new base_addr.
REQ-037 A bench SHALL cover: num_bursts=0 -> done one cycle after start, no awvalid; start while busy ignored.
